// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer onto a single-port word memory: sub-word loads extend, sub-word stores read-modify-write.
// Done 2 cycles after accept (3 for RMW) with ready held; stalls while busy. MEMCTRL_MISALIGN_TRAP_EN traps misalignment.
module mem_access_ctrl #(
  parameter int MEM_AW  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_size,
  input  logic              req_unsigned,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] SZ_BYTE = 4'b0001;
  localparam logic [3:0] SZ_HALF = 4'b0011;
  localparam logic [3:0] SZ_WORD = 4'b1111;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state;
  logic              we_q;
  logic              uns_q;
  logic [MEM_AW+1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [3:0]        size_q;
  logic [CW-1:0]     cnt;

  logic        size_ok;
  logic        misalign;
  logic        cnt_last;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        unused_bits;

  assign unused_bits = ^{req_addr[31:MEM_AW+2], req_wdata[31:16]};

  assign size_ok  = (req_size == SZ_BYTE) || (req_size == SZ_HALF) || (req_size == SZ_WORD);
`ifdef MEMCTRL_MISALIGN_TRAP_EN
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign cnt_last = (cnt == CW'(TIMEOUT - 1));
  assign mem_en   = (state == RD) || (state == WR);
  assign mem_we   = (state == WR);
  assign done     = (state == RESP);
  assign stall    = req_valid & ~done;
  assign mem_addr = addr_q[MEM_AW+1:2];

  // Half accesses select on addr[1] only, so a stray addr[0] is ignored when not trapped.
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_val = mem_rdata;
    merged   = mem_rdata;
    if (size_q == SZ_BYTE) begin
      load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == SZ_HALF) begin
      load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      err       <= 1'b0;
      rdata     <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr[MEM_AW+1:0];
            wdata_q <= req_wdata[15:0];
            size_q  <= req_size;
            cnt     <= '0;
            if (!size_ok || misalign) begin
              err   <= 1'b1;
              state <= RESP;
            end else if (req_we && (req_size == SZ_WORD)) begin
              mem_wdata <= req_wdata;
              state     <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (mem_ready) begin
            cnt <= '0;
            if (we_q) begin
              mem_wdata <= merged;
              state     <= WR;
            end else begin
              rdata <= load_val;
              state <= RESP;
            end
          end else if (cnt_last) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          if (mem_ready) begin
            state <= RESP;
          end else if (cnt_last) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases with literal expectations, then randomized traffic
// against a transaction-level model that tracks the memory phases each access still owes.
module tb_mem_access_ctrl;
  localparam int MEM_AW  = 10;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_size;
  logic              req_unsigned;
  logic              stall;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  mem_access_ctrl #(.MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned), .stall(stall),
    .done(done), .err(err), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_arr [0:(1<<MEM_AW)-1];
  logic [31:0] ref_mem [0:(1<<MEM_AW)-1];
  assign mem_rdata = mem_arr[mem_addr];

  int n_chk = 0;
  int n_fail = 0;

  // Model state: phases still owed (0 = read, 1 = write), pending response, expected results.
  int          q[$];
  int          m_wait;
  bit          m_resp;
  logic        m_err;
  logic [31:0] m_rdata;
  logic [31:0] m_wword;
  logic        m_we, m_uns;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_size;

  int          ready_mode;
  bit          saw_done;
  logic        done_err;
  logic [31:0] done_rdata;
  int          n_rd, n_wr, n_en;
  logic [MEM_AW-1:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [31:0] a,
                                          input logic [3:0] s, input logic uns);
    int sh;
    logic [31:0] v;
    if (s == 4'b0001) begin
      sh = int'(a[1:0]) * 8;
      v = (w >> sh) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (s == 4'b0011) begin
      sh = a[1] ? 16 : 0;
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] a,
                                        input logic [3:0] s, input logic [31:0] d);
    int sh;
    logic [31:0] mask;
    mask = (s == 4'b0001) ? 32'hFF : 32'hFFFF;
    sh = (s == 4'b0001) ? int'(a[1:0]) * 8 : (a[1] ? 16 : 0);
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  function automatic bit rejected(input logic [31:0] a, input logic [3:0] s);
    bit bad;
    bad = !(s == 4'b0001 || s == 4'b0011 || s == 4'b1111);
`ifdef MEMCTRL_MISALIGN_TRAP_EN
    if (s == 4'b0011 && a[0]) bad = 1'b1;
    if (s == 4'b1111 && a[1:0] != 2'b00) bad = 1'b1;
`endif
    return bad;
  endfunction

  // Called just after a falling edge with this cycle's request inputs already driven.
  task automatic step();
    logic [MEM_AW-1:0] widx;
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ($urandom_range(0, 3) != 0);
      default: mem_ready = 1'b0;
    endcase
    #1;
    chk("done", {31'b0, done}, {31'b0, m_resp});
    chk("stall", {31'b0, stall}, {31'b0, req_valid & ~m_resp});
    chk("mem_en", {31'b0, mem_en}, {31'b0, q.size() > 0});
    chk("mem_we", {31'b0, mem_we}, {31'b0, (q.size() > 0) ? (q[0] == 1) : 1'b0});
    chk("rdata", rdata, m_rdata);
    if (m_resp) chk("err", {31'b0, err}, {31'b0, m_err});
    if (q.size() > 0) chk("mem_addr", {22'b0, mem_addr}, {22'b0, m_addr[MEM_AW+1:2]});
    if (q.size() > 0 && q[0] == 1) chk("mem_wdata", mem_wdata, m_wword);

    if (mem_en) n_en++;
    if (mem_en && mem_ready) begin
      last_addr = mem_addr;
      if (mem_we) begin
        mem_arr[mem_addr] = mem_wdata;
        n_wr++;
      end else begin
        n_rd++;
      end
    end
    if (done) begin
      saw_done = 1'b1;
      done_err = err;
      done_rdata = rdata;
    end

    if (m_resp) begin
      m_resp = 1'b0;
    end else if (q.size() > 0) begin
      if (mem_ready) begin
        widx = m_addr[MEM_AW+1:2];
        if (q[0] == 0) begin
          if (m_we) m_wword = merge(ref_mem[widx], m_addr, m_size, m_wdata);
          else m_rdata = extract(ref_mem[widx], m_addr, m_size, m_uns);
        end else begin
          ref_mem[widx] = m_wword;
        end
        void'(q.pop_front());
        m_wait = 0;
        if (q.size() == 0) m_resp = 1'b1;
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          q.delete();
          m_err = 1'b1;
          m_resp = 1'b1;
        end
      end
    end else if (req_valid) begin
      m_we = req_we; m_uns = req_unsigned; m_addr = req_addr; m_wdata = req_wdata; m_size = req_size;
      m_wait = 0;
      m_err = 1'b0;
      if (rejected(req_addr, req_size)) begin
        m_err = 1'b1;
        m_resp = 1'b1;
      end else if (!req_we) begin
        q.push_back(0);
      end else if (req_size == 4'b1111) begin
        m_wword = req_wdata;
        q.push_back(1);
      end else begin
        q.push_back(0);
        q.push_back(1);
      end
    end
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] size, input logic uns, input int mode, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    ready_mode = mode;
    saw_done = 1'b0;
    lat = -1;
    step();
    for (int c = 1; c < 200 && !saw_done; c++) begin
      @(negedge clk);
      step();
      if (saw_done) lat = c;
    end
    if (!saw_done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_budget: got no done within 200 cycles, required a done pulse");
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_size = 4'($urandom);
    step();
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    mem_arr[idx] = w;
    ref_mem[idx] = w;
  endtask

  initial begin
    int lat, rd0, wr0, en0;
    logic [31:0] keep;
    logic [3:0] bad_codes [5];
    bad_codes = '{4'b0000, 4'b0010, 4'b0100, 4'b0111, 4'b1000};

    for (int i = 0; i < (1 << MEM_AW); i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    m_resp = 1'b0; m_err = 1'b0; m_rdata = '0; m_wword = '0; m_wait = 0;
    n_rd = 0; n_wr = 0; n_en = 0; ready_mode = 0; saw_done = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word load
    preload(4, 32'hDEADBEEF);
    en0 = n_en;
    run_req(1'b0, 32'h10, 32'h0, 4'b1111, 1'b0, 0, lat);
    chk("lw_latency", lat, 2);
    chk("lw_rdata", done_rdata, 32'hDEADBEEF);
    chk("lw_err", {31'b0, done_err}, 32'd0);
    chk("lw_mem_addr", {22'b0, last_addr}, 32'd4);
    chk("lw_en_cycles", n_en - en0, 1);

    // Byte loads, signed and unsigned
    preload(4, 32'h80FFFFFF);
    run_req(1'b0, 32'h13, 32'h0, 4'b0001, 1'b0, 0, lat);
    chk("lb_rdata", done_rdata, 32'hFFFFFF80);
    run_req(1'b0, 32'h13, 32'h0, 4'b0001, 1'b1, 0, lat);
    chk("lbu_rdata", done_rdata, 32'h00000080);

    // Sub-word store read-modify-write
    preload(8, 32'h11223344);
    rd0 = n_rd; wr0 = n_wr;
    run_req(1'b1, 32'h22, 32'h000000AB, 4'b0001, 1'b0, 0, lat);
    chk("sb_latency", lat, 3);
    chk("sb_reads", n_rd - rd0, 1);
    chk("sb_writes", n_wr - wr0, 1);
    chk("sb_word", mem_arr[8], 32'h11AB3344);

    // Timeout on a load
    wr0 = n_wr; en0 = n_en;
    run_req(1'b0, 32'h30, 32'h0, 4'b1111, 1'b0, 2, lat);
    chk("to_latency", lat, 1 + TIMEOUT);
    chk("to_err", {31'b0, done_err}, 32'd1);
    chk("to_writes", n_wr - wr0, 0);
    chk("to_en_cycles", n_en - en0, TIMEOUT);

    // Misaligned half load
    preload(0, 32'h12348001);
    en0 = n_en;
    run_req(1'b0, 32'h01, 32'h0, 4'b0011, 1'b0, 0, lat);
`ifdef MEMCTRL_MISALIGN_TRAP_EN
    chk("lh_mis_err", {31'b0, done_err}, 32'd1);
    chk("lh_mis_latency", lat, 1);
    chk("lh_mis_en", n_en - en0, 0);
`else
    chk("lh_mis_err", {31'b0, done_err}, 32'd0);
    chk("lh_mis_latency", lat, 2);
    chk("lh_mis_rdata", done_rdata, 32'hFFFF8001);
`endif

    // Invalid size code
    en0 = n_en;
    run_req(1'b0, 32'h0, 32'h0, 4'b0010, 1'b0, 0, lat);
    chk("bad_size_err", {31'b0, done_err}, 32'd1);
    chk("bad_size_latency", lat, 1);
    chk("bad_size_en", n_en - en0, 0);

    // Reset while a word store waits in WR
    preload(16, 32'hCAFEF00D);
    keep = mem_arr[16];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_size = 4'b1111;
    ready_mode = 2;
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_mid_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mid_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    q.delete(); m_resp = 1'b0; m_err = 1'b0; m_rdata = '0; m_wait = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_hold_done", {31'b0, done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_no_write", mem_arr[16], keep);
    run_req(1'b0, 32'h40, 32'h0, 4'b1111, 1'b0, 0, lat);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_rdata", done_rdata, 32'hCAFEF00D);

    // Randomized traffic against the model
    for (int t = 0; t < 250; t++) begin
      logic [3:0] sz;
      int r, mode;
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 4'b0001 : (r < 6) ? 4'b0011 : (r < 9) ? 4'b1111 : bad_codes[$urandom_range(0, 4)];
      mode = ($urandom_range(0, 19) == 0) ? 2 : (($urandom_range(0, 3) == 0) ? 0 : 1);
      run_req(1'($urandom), $urandom & ~32'h0000_0FC0, $urandom, sz, 1'($urandom), mode, lat);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    for (int i = 0; i < 64; i++) chk("final_mem", mem_arr[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences MEM-stage accesses from the pipeline onto a single-ported, word-wide data memory with a ready handshake.
- Performs sub-word loads: byte/half lane extraction with sign or zero extension.
- Performs sub-word stores as read-modify-write.
- Stalls the pipeline while an access is in flight. Sits between the control unit's memory-size decode and the data memory.

Parameters:
- MEM_AW, 10: word-address width of the data memory.
- TIMEOUT, 16: maximum cycles spent in RD or WR waiting for mem_ready before the access aborts. Must be >= 1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM-stage access request; held stable by the pipeline until done
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; byte/half taken from low bits
- req_size  in  4  0001 = byte, 0011 = half, 1111 = word; other codes are invalid
- req_unsigned  in  1  zero-extend loads (LBU/LHU); 0 = sign-extend
- stall  out  1  hold pipeline
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; access aborted or rejected
- rdata  out  32  extended load result, valid with done, held until next done
- mem_en  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  MEM_AW  word address = latched addr[MEM_AW+1:2]
- mem_wdata  out  32  word to write
- mem_rdata  in  32  memory read word, valid when mem_ready
- mem_ready  in  1  memory accepted/completed current cycle

Behaviour:
- Reset: asynchronous, active-low.
  - State IDLE; done, err, mem_en, mem_we = 0.
  - rdata, mem_wdata, latched request and timeout counter = 0.
- Reset mid-access: immediate return to IDLE; mem_en drops with reset assertion; no write completes afterward.
- States: IDLE, RD, WR, RESP.
  - mem_en = (RD or WR).
  - mem_we = WR.
  - stall = req_valid & ~done.
- IDLE, on req_valid: latch all req_* fields.
  - Invalid size or misalignment (see Optional Feature) -> RESP with err = 1, no memory access.
  - Load -> RD.
  - Word store -> WR with mem_wdata = wdata.
  - Byte/half store -> RD (RMW).
- RD: hold mem_en until mem_ready.
  - On mem_ready with a load: extract lane and extend into rdata -> RESP.
  - On mem_ready with RMW: merge the new byte/half into mem_rdata, register it to mem_wdata -> WR.
- WR: hold mem_en/mem_we until mem_ready -> RESP.
- RESP: done = 1 for exactly one cycle -> IDLE. req_valid is ignored in RESP; a new request is accepted from IDLE on the next cycle.
- Lanes are little-endian.
  - Byte lane k = addr[1:0], bits [8k+7:8k].
  - Half lane h = addr[1], bits [16h+15:16h].
  - Word loads pass mem_rdata through unchanged.
- Timeout:
  - Counter clears on entering RD or WR and increments each waiting cycle without mem_ready.
  - When the count reaches TIMEOUT: go to RESP with err = 1, rdata unchanged, no write merge. mem_en is low in RESP.
  - mem_ready in the same cycle the count reaches TIMEOUT counts as success.
- Latency with mem_ready = 1 in every RD/WR cycle (request seen at cycle 0):
  - Word load / word store: done at cycle 2.
  - Sub-word store: done at cycle 3.

Optional Feature:
- Macro: MEMCTRL_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, gets err = 1, no memory access, done 1 cycle after acceptance.
- Undefined: misaligned low bits are forced to zero (half uses addr[1] only; word ignores addr[1:0]); the access proceeds normally with err = 0.
- Invalid req_size errors in both builds.

Test Plan:
- Word load, addr 0x10, mem_rdata 0xDEADBEEF, ready always 1 -> mem_addr 4, done at cycle 2, rdata 0xDEADBEEF, err 0, stall high cycles 0-1.
- LB signed addr 0x13, mem_rdata 0x80FFFFFF -> rdata 0xFFFFFF80; same with req_unsigned = 1 -> rdata 0x00000080.
- SB addr 0x22, wdata 0x000000AB, memory word 0x11223344 -> one read, then one write of 0x11AB3344, done at cycle 3.
- mem_ready held low -> after TIMEOUT = 16 waiting cycles, done with err = 1, mem_en low in RESP, no mem_we pulse.
- LH addr 0x01 -> with MEMCTRL_MISALIGN_TRAP_EN: err = 1, mem_en never asserted. Without it: reads word 0, returns sign-extended bits [15:0].
- rst_n low while in WR with ready low -> state IDLE, mem_en/mem_we 0 immediately, no done pulse; next request after release completes normally.
